sorted_result_streamer: RTL and testbench
=========================================

Name: sorted_result_streamer

Overview:
- Consumer end of the sorter's packed output interface.
- Captures one packed, sorted vector (data_out/cks_out of bubble_sorting_top) on its strobe.
- Streams the elements out one per transfer over a valid/ready byte stream, element 0 first.
- Checks non-decreasing order and flags overruns; sits between the sorter and downstream logic (UART/LED/host interface).

Parameters:
- input_num, 8, number of elements in the packed vector (>=1).
- data_w, 8, width of one element.
- IDX_W, derived, $clog2(input_num>1 ? input_num : 2); localparam, not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- data_in  in  input_num*data_w  packed vector; element k at [k*data_w +: data_w].
- cks_in  in  1  one-cycle strobe marking data_in valid.
- in_ready  out  1  high when a new vector can be captured.
- m_data  out  data_w  current element.
- m_valid  out  1  m_data/m_index/m_last valid.
- m_ready  in  1  downstream accepts when high with m_valid.
- m_last  out  1  high with the final element (index input_num-1).
- m_index  out  IDX_W  index of the element on m_data.
- order_err  out  1  sticky; captured vector was not non-decreasing.
- overrun  out  1  sticky; cks_in arrived while in_ready=0.

Behaviour:
- Reset values (async, immediate): state=IDLE, in_ready=1, m_valid=0, m_data=0, m_index=0, m_last=0, order_err=0, overrun=0, buffer=0.
- States:
  - IDLE: in_ready=1 (decoded from state), m_valid=0.
  - SEND: in_ready=0, m_valid=1.
- IDLE->SEND on a clk edge with cks_in=1:
  - buffer<=data_in, m_index<=0, m_data<=element 0, m_last<=(input_num==1).
  - Latency: element 0 is on m_data with m_valid=1 the cycle after the strobe edge.
- Transfer = m_valid & m_ready at a clk edge.
  - On transfer with m_index<input_num-1: m_index+1, m_data<=next element, m_last<=(new index==input_num-1).
  - On transfer with m_last=1: SEND->IDLE, m_valid<=0, m_index<=0.
  - Full throughput: one element per cycle while m_ready=1.
  - m_data, m_index and m_last must hold stable while m_valid=1 and m_ready=0.
- Order check, evaluated combinationally on data_in at capture:
  - If any k has elem[k] > elem[k+1] (unsigned), order_err<=1.
  - order_err stays set until rst. Data is still streamed unchanged.
- cks_in while in SEND, including the cycle of the final transfer:
  - vector dropped, overrun<=1 (sticky until rst), stream continues unaffected.
  - No back-to-back capture: in_ready only rises the cycle after the last transfer.
- input_num=1: single transfer with m_last=1 immediately; order_err can never set.
- rst asserted mid-stream: stream aborted at once, all outputs to reset values. The first cks_in after release is captured normally.
- Registered outputs: m_data, m_valid, m_index, m_last, order_err, overrun. No combinational path from m_ready to m_valid/m_data. in_ready is decoded from state only.

Decomposition:
- Shared package (sort_pkg): data_w and input_num defaults, state encoding (IDLE/SEND).
- Same package: function elem(vec,k) for the packed slice, and function is_nondecreasing(vec).
- One natural sub-module: sort_order_checker (combinational, packed vector in, 1-bit ok out), reusable by the sorter's own bench.
- Remaining datapath and FSM stay in the top.

Test Plan:
1. input_num=3, data_in={8'd225,8'd185,8'd99}, cks_in pulse, m_ready=1 -> m_data 99,185,225 on three consecutive cycles; m_index 0,1,2; m_last only with 225; order_err=0; in_ready back to 1 the cycle after.
2. Same vector, m_ready toggled 1,0,0,1,1 -> outputs hold 185/index 1 through the stall cycles; exactly three transfers; no duplicate or skipped element.
3. data_in={8'd99,8'd185,8'd225} (elem0=225 > elem1=185) -> order_err=1 after capture; stream is 225,185,99; order_err stays 1 after return to IDLE.
4. Second cks_in pulse two cycles into a stream with m_ready=0 -> overrun=1; first vector's elements still delivered intact; second vector never appears.
5. rst pulsed while m_index=1 -> m_valid=0 and in_ready=1 immediately (async); after release, vector {8'd3,8'd2,8'd1} streams as 1,2,3 from index 0.
6. input_num=1, data_in=8'd42, cks_in pulse -> single transfer of 42 with m_last=1 and m_index=0; order_err=0.

Source files
------------

// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared defaults, state encoding and packed-vector helpers
//
// Purpose: common definitions for the sorter output path.
//   DATA_W_DEF / INPUT_NUM_DEF : default element width and element count.
//   state_t                    : streamer FSM encoding (ST_IDLE / ST_SEND).
//   elem(vec,k,w)              : element k of width w from a packed vector.
//   is_nondecreasing(vec,n,w)  : 1 when elements 0..n-1 are in non-decreasing order (unsigned).
// Vectors are zero-extended to MAX_VEC_W so one helper serves every parameterisation.
// Vectors wider than MAX_VEC_W are not supported.
// At most MAX_ELEMS elements are compared.
// Elements wider than MAX_DATA_W are not supported.
package sort_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int INPUT_NUM_DEF = 8;
  localparam int MAX_DATA_W    = 32;
  localparam int MAX_VEC_W     = 256;
  localparam int MAX_ELEMS     = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  function automatic logic [MAX_DATA_W-1:0] elem(input logic [MAX_VEC_W-1:0] vec,
                                                 input int k, input int w);
    logic [MAX_DATA_W-1:0] mask;
    mask = (w >= MAX_DATA_W) ? '1 : ((MAX_DATA_W'(1) << w) - MAX_DATA_W'(1));
    return MAX_DATA_W'(vec >> (k * w)) & mask;
  endfunction

  // Loop bound is a constant so synthesis can unroll it.
  // Pairs beyond n are masked off by the k < n-1 test.
  function automatic logic is_nondecreasing(input logic [MAX_VEC_W-1:0] vec,
                                            input int n, input int w);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < MAX_ELEMS - 1; k++) begin
      if ((k < n - 1) && (elem(vec, k, w) > elem(vec, k + 1, w))) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/sorted_result_streamer_if.sv
// rtl/sorted_result_streamer_if.sv - capture and stream bundle for sorted_result_streamer
//
// Purpose: groups the packed-vector capture port and the element stream.
//   data_in/cks_in -> in_ready   : packed vector and its one-cycle strobe.
//   m_data/m_index/m_last/m_valid: element stream, accepted by m_ready.
//   order_err, overrun           : sticky status flags.
// Modports:
//   slave  : the streamer itself.
//   master : the environment that feeds vectors and consumes the stream.
interface sorted_result_streamer_if
  import sort_pkg::*;
#(
  parameter int input_num = INPUT_NUM_DEF,
  parameter int data_w    = DATA_W_DEF
);
  localparam int IDX_W = $clog2(input_num > 1 ? input_num : 2);

  logic [input_num*data_w-1:0] data_in;
  logic                        cks_in;
  logic                        in_ready;
  logic [data_w-1:0]           m_data;
  logic                        m_valid;
  logic                        m_ready;
  logic                        m_last;
  logic [IDX_W-1:0]            m_index;
  logic                        order_err;
  logic                        overrun;

  modport slave (
    input  data_in, cks_in, m_ready,
    output in_ready, m_data, m_valid, m_last, m_index, order_err, overrun
  );

  modport master (
    output data_in, cks_in, m_ready,
    input  in_ready, m_data, m_valid, m_last, m_index, order_err, overrun
  );

endinterface

// File: rtl/sort_order_checker.sv
// rtl/sort_order_checker.sv - combinational non-decreasing order check of a packed vector
//
// Purpose: ok=1 when every element k <= element k+1 (unsigned).
//   vec : packed vector, element k at [k*data_w +: data_w].
//   ok  : order flag.
// A single element is always in order.
module sort_order_checker
  import sort_pkg::*;
#(
  parameter int input_num = INPUT_NUM_DEF,
  parameter int data_w    = DATA_W_DEF
) (
  input  logic [input_num*data_w-1:0] vec,
  output logic                        ok
);

  assign ok = is_nondecreasing(MAX_VEC_W'(vec), input_num, data_w);

endmodule

// File: rtl/sorted_result_streamer.sv
// rtl/sorted_result_streamer.sv - captures a packed sorted vector and streams its elements
//
// Purpose: consumer end of the sorter output.
//   Captures data_in on cks_in while idle.
//   Streams the elements over m_* with element 0 first.
//   Flags out-of-order vectors (order_err) and strobes that arrive while busy (overrun).
// Ports:
//   clk    : rising-edge clock.
//   rst    : asynchronous active-high reset.
//   bus    : sorted_result_streamer_if.slave.
//            data_in, cks_in, m_ready           : inputs.
//            in_ready                           : output, decoded from state.
//            m_data, m_valid, m_last, m_index,
//            order_err, overrun                 : outputs, all registered.
module sorted_result_streamer
  import sort_pkg::*;
#(
  parameter int input_num = INPUT_NUM_DEF,
  parameter int data_w    = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  sorted_result_streamer_if.slave  bus
);

  localparam int IDX_W = $clog2(input_num > 1 ? input_num : 2);
  localparam int VEC_W = input_num * data_w;

  state_t state_q, state_d;

  logic [VEC_W-1:0]  buffer_q;
  logic [data_w-1:0] m_data_q;
  logic              m_valid_q;
  logic              m_last_q;
  logic [IDX_W-1:0]  m_index_q;
  logic              order_err_q;
  logic              overrun_q;

  logic              vec_ok;
  logic              capture;
  logic              xfer;
  logic [IDX_W-1:0]  next_idx;
  logic [data_w-1:0] first_elem;
  logic [data_w-1:0] next_elem;

  sort_order_checker #(
    .input_num (input_num),
    .data_w    (data_w)
  ) u_order_checker (
    .vec (bus.data_in),
    .ok  (vec_ok)
  );

  assign capture    = (state_q == ST_IDLE) && bus.cks_in;
  assign xfer       = m_valid_q && bus.m_ready;
  assign next_idx   = m_index_q + 1'b1;
  assign first_elem = data_w'(elem(MAX_VEC_W'(bus.data_in), 0, data_w));
  // Only used when m_last is low, so next_idx is always a real element here.
  assign next_elem  = data_w'(elem(MAX_VEC_W'(buffer_q), int'(next_idx), data_w));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.cks_in) state_d = ST_SEND;
      ST_SEND: if (xfer && m_last_q) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: in_ready depends on state only, never on m_ready.
  always_comb begin
    bus.in_ready = 1'b0;
    if (state_q == ST_IDLE) bus.in_ready = 1'b1;
  end

  // Datapath: capture buffer, element stream registers and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buffer_q    <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_index_q   <= '0;
      order_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (capture) begin
        buffer_q  <= bus.data_in;
        m_data_q  <= first_elem;
        m_valid_q <= 1'b1;
        m_index_q <= '0;
        m_last_q  <= (input_num == 1);
        if (!vec_ok) order_err_q <= 1'b1;
      end else if (xfer) begin
        if (m_last_q) begin
          m_valid_q <= 1'b0;
          m_last_q  <= 1'b0;
          m_index_q <= '0;
        end else begin
          m_index_q <= next_idx;
          m_data_q  <= next_elem;
          m_last_q  <= (next_idx == IDX_W'(input_num - 1));
        end
      end
      // A strobe while streaming, including on the last transfer, drops that vector.
      if ((state_q == ST_SEND) && bus.cks_in) overrun_q <= 1'b1;
    end
  end

  assign bus.m_data    = m_data_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_last    = m_last_q;
  assign bus.m_index   = m_index_q;
  assign bus.order_err = order_err_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_sorted_result_streamer.sv
// tb/tb_sorted_result_streamer.sv - directed self-checking bench for sorted_result_streamer
module tb_sorted_result_streamer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sorted_result_streamer_if #(.input_num(3), .data_w(8)) if3 ();
  sorted_result_streamer_if #(.input_num(1), .data_w(8)) if1 ();

  sorted_result_streamer #(.input_num(3), .data_w(8)) dut3 (.clk(clk), .rst(rst), .bus(if3));
  sorted_result_streamer #(.input_num(1), .data_w(8)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    if3.data_in = '0; if3.cks_in = 1'b0; if3.m_ready = 1'b0;
    if1.data_in = '0; if1.cks_in = 1'b0; if1.m_ready = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    vectors++; if (if3.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", if3.in_ready); end
    vectors++; if (if3.m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_m_valid: got %b want 0", if3.m_valid); end
    vectors++; if (if3.m_data !== 8'd0) begin miscompares++; $display("FAIL reset_m_data: got %0d want 0", if3.m_data); end
    vectors++; if (if3.m_index !== 2'd0) begin miscompares++; $display("FAIL reset_m_index: got %0d want 0", if3.m_index); end
    vectors++; if (if3.m_last !== 1'b0) begin miscompares++; $display("FAIL reset_m_last: got %b want 0", if3.m_last); end
    vectors++; if (if3.order_err !== 1'b0) begin miscompares++; $display("FAIL reset_order_err: got %b want 0", if3.order_err); end
    vectors++; if (if3.overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b want 0", if3.overrun); end
    vectors++; if (if1.in_ready !== 1'b1 || if1.m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_n1: in_ready %b m_valid %b want 1 0", if1.in_ready, if1.m_valid); end
    rst = 1'b0;
    tick();
    vectors++; if (if3.in_ready !== 1'b1 || if3.m_valid !== 1'b0) begin miscompares++; $display("FAIL idle_after_release: in_ready %b m_valid %b want 1 0", if3.in_ready, if3.m_valid); end
  endtask

  task automatic test_stream();
    logic [7:0] exp_d [3] = '{8'd99, 8'd185, 8'd225};
    if3.data_in = {8'd225, 8'd185, 8'd99};
    if3.cks_in = 1'b1; if3.m_ready = 1'b1;
    tick();
    if3.cks_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++; if (if3.m_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid[%0d]: got %b want 1", i, if3.m_valid); end
      vectors++; if (if3.m_data !== exp_d[i]) begin miscompares++; $display("FAIL stream_data[%0d]: got %0d want %0d", i, if3.m_data, exp_d[i]); end
      vectors++; if (if3.m_index !== 2'(i)) begin miscompares++; $display("FAIL stream_index[%0d]: got %0d want %0d", i, if3.m_index, i); end
      vectors++; if (if3.m_last !== (i == 2)) begin miscompares++; $display("FAIL stream_last[%0d]: got %b want %b", i, if3.m_last, (i == 2)); end
      vectors++; if (if3.in_ready !== 1'b0) begin miscompares++; $display("FAIL stream_in_ready[%0d]: got %b want 0", i, if3.in_ready); end
      tick();
    end
    vectors++; if (if3.m_valid !== 1'b0) begin miscompares++; $display("FAIL stream_end_valid: got %b want 0", if3.m_valid); end
    vectors++; if (if3.in_ready !== 1'b1) begin miscompares++; $display("FAIL stream_end_in_ready: got %b want 1", if3.in_ready); end
    vectors++; if (if3.order_err !== 1'b0) begin miscompares++; $display("FAIL stream_order_err: got %b want 0", if3.order_err); end
  endtask

  task automatic test_backpressure();
    logic       rpat [5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] exp_d [5] = '{8'd99, 8'd185, 8'd185, 8'd185, 8'd225};
    logic [1:0] exp_i [5] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2};
    int xfers = 0;
    if3.data_in = {8'd225, 8'd185, 8'd99};
    if3.cks_in = 1'b1; if3.m_ready = 1'b0;
    tick();
    if3.cks_in = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if3.m_ready = rpat[c];
      vectors++; if (if3.m_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid[%0d]: got %b want 1", c, if3.m_valid); end
      vectors++; if (if3.m_data !== exp_d[c]) begin miscompares++; $display("FAIL bp_data[%0d]: got %0d want %0d", c, if3.m_data, exp_d[c]); end
      vectors++; if (if3.m_index !== exp_i[c]) begin miscompares++; $display("FAIL bp_index[%0d]: got %0d want %0d", c, if3.m_index, exp_i[c]); end
      vectors++; if (if3.m_last !== (c == 4)) begin miscompares++; $display("FAIL bp_last[%0d]: got %b want %b", c, if3.m_last, (c == 4)); end
      if (if3.m_valid && if3.m_ready) xfers++;
      tick();
    end
    if3.m_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (if3.m_valid && if3.m_ready) xfers++;
      tick();
    end
    vectors++; if (xfers != 3) begin miscompares++; $display("FAIL bp_transfer_count: got %0d want 3", xfers); end
    vectors++; if (if3.in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_end_in_ready: got %b want 1", if3.in_ready); end
  endtask

  task automatic test_order_err();
    logic [7:0] exp_d [3] = '{8'd225, 8'd185, 8'd99};
    if3.data_in = {8'd99, 8'd185, 8'd225};
    if3.cks_in = 1'b1; if3.m_ready = 1'b1;
    tick();
    if3.cks_in = 1'b0;
    vectors++; if (if3.order_err !== 1'b1) begin miscompares++; $display("FAIL order_err_set: got %b want 1", if3.order_err); end
    for (int i = 0; i < 3; i++) begin
      vectors++; if (if3.m_valid !== 1'b1 || if3.m_data !== exp_d[i]) begin miscompares++; $display("FAIL order_data[%0d]: valid %b data %0d want 1 %0d", i, if3.m_valid, if3.m_data, exp_d[i]); end
      tick();
    end
    tick();
    vectors++; if (if3.m_valid !== 1'b0) begin miscompares++; $display("FAIL order_end_valid: got %b want 0", if3.m_valid); end
    vectors++; if (if3.order_err !== 1'b1) begin miscompares++; $display("FAIL order_err_sticky: got %b want 1", if3.order_err); end
    vectors++; if (if3.overrun !== 1'b0) begin miscompares++; $display("FAIL order_overrun: got %b want 0", if3.overrun); end
  endtask

  task automatic test_overrun();
    logic [7:0] exp_d [3] = '{8'd99, 8'd185, 8'd225};
    if3.data_in = {8'd225, 8'd185, 8'd99};
    if3.cks_in = 1'b1; if3.m_ready = 1'b0;
    tick();
    if3.cks_in = 1'b0;
    tick();
    if3.data_in = {8'd3, 8'd2, 8'd1};
    if3.cks_in = 1'b1;
    tick();
    if3.cks_in = 1'b0;
    vectors++; if (if3.overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_set: got %b want 1", if3.overrun); end
    vectors++; if (if3.m_data !== 8'd99 || if3.m_index !== 2'd0) begin miscompares++; $display("FAIL overrun_hold: data %0d index %0d want 99 0", if3.m_data, if3.m_index); end
    if3.m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vectors++; if (if3.m_valid !== 1'b1 || if3.m_data !== exp_d[i] || if3.m_index !== 2'(i)) begin miscompares++; $display("FAIL overrun_data[%0d]: valid %b data %0d index %0d want 1 %0d %0d", i, if3.m_valid, if3.m_data, if3.m_index, exp_d[i], i); end
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      vectors++; if (if3.m_valid !== 1'b0) begin miscompares++; $display("FAIL overrun_no_second[%0d]: m_valid %b data %0d want 0", c, if3.m_valid, if3.m_data); end
      tick();
    end
    vectors++; if (if3.overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_sticky: got %b want 1", if3.overrun); end
  endtask

  task automatic test_reset_midstream();
    logic [7:0] exp_d [3] = '{8'd1, 8'd2, 8'd3};
    if3.data_in = {8'd225, 8'd185, 8'd99};
    if3.cks_in = 1'b1; if3.m_ready = 1'b1;
    tick();
    if3.cks_in = 1'b0;
    tick();
    vectors++; if (if3.m_index !== 2'd1) begin miscompares++; $display("FAIL mid_index_before_rst: got %0d want 1", if3.m_index); end
    if3.m_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    vectors++; if (if3.m_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid: got %b want 0", if3.m_valid); end
    vectors++; if (if3.in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_rst_in_ready: got %b want 1", if3.in_ready); end
    vectors++; if (if3.m_index !== 2'd0 || if3.m_data !== 8'd0 || if3.m_last !== 1'b0) begin miscompares++; $display("FAIL mid_rst_outputs: index %0d data %0d last %b want 0 0 0", if3.m_index, if3.m_data, if3.m_last); end
    vectors++; if (if3.order_err !== 1'b0 || if3.overrun !== 1'b0) begin miscompares++; $display("FAIL mid_rst_flags: order_err %b overrun %b want 0 0", if3.order_err, if3.overrun); end
    tick();
    rst = 1'b0;
    if3.data_in = {8'd3, 8'd2, 8'd1};
    if3.cks_in = 1'b1; if3.m_ready = 1'b1;
    tick();
    if3.cks_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++; if (if3.m_valid !== 1'b1 || if3.m_data !== exp_d[i] || if3.m_index !== 2'(i)) begin miscompares++; $display("FAIL post_rst_data[%0d]: valid %b data %0d index %0d want 1 %0d %0d", i, if3.m_valid, if3.m_data, if3.m_index, exp_d[i], i); end
      tick();
    end
    vectors++; if (if3.m_valid !== 1'b0 || if3.order_err !== 1'b0) begin miscompares++; $display("FAIL post_rst_end: valid %b order_err %b want 0 0", if3.m_valid, if3.order_err); end
  endtask

  task automatic test_single();
    if1.data_in = 8'd42;
    if1.cks_in = 1'b1; if1.m_ready = 1'b1;
    tick();
    if1.cks_in = 1'b0;
    vectors++; if (if1.m_valid !== 1'b1 || if1.m_data !== 8'd42) begin miscompares++; $display("FAIL single_data: valid %b data %0d want 1 42", if1.m_valid, if1.m_data); end
    vectors++; if (if1.m_last !== 1'b1 || if1.m_index !== 1'b0) begin miscompares++; $display("FAIL single_last_index: last %b index %0d want 1 0", if1.m_last, if1.m_index); end
    vectors++; if (if1.in_ready !== 1'b0) begin miscompares++; $display("FAIL single_in_ready_busy: got %b want 0", if1.in_ready); end
    tick();
    vectors++; if (if1.m_valid !== 1'b0 || if1.in_ready !== 1'b1) begin miscompares++; $display("FAIL single_end: valid %b in_ready %b want 0 1", if1.m_valid, if1.in_ready); end
    vectors++; if (if1.order_err !== 1'b0 || if1.overrun !== 1'b0) begin miscompares++; $display("FAIL single_flags: order_err %b overrun %b want 0 0", if1.order_err, if1.overrun); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_order_err();
    test_overrun();
    test_reset_midstream();
    test_single();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
